// File: rtl/core_mem_slave_pkg.sv
// Shared constants and types for the core memory slave.
//   CORE_ADDR_WIDTH / CORE_DATA_WIDTH / CORE_BE_WIDTH : default bus geometry
//   ERR_DATA     : read data returned for addresses beyond the array
//   gnt_state_e  : grant FSM encoding
package core_pkg;

   localparam int          CORE_ADDR_WIDTH = 32;
   localparam int          CORE_DATA_WIDTH = 32;
   localparam int          CORE_BE_WIDTH   = CORE_DATA_WIDTH / 8;
   localparam logic [31:0] ERR_DATA        = 32'hDEAD_BEEF;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } gnt_state_e;

endpackage

// File: rtl/core_mem_slave_if.sv
// Request/grant + in-order response bus between a master and the memory slave.
//   master -> slave : req, addr, we, be, wdata
//   slave -> master : gnt, rvalid, rdata
interface core_mem_slave_if import core_pkg::*; #(
   parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
   parameter int DATA_WIDTH = CORE_DATA_WIDTH
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/core_mem_slave_rsp_pipe.sv
// Fixed-latency response pipeline: RSP_LAT stages of valid + data.
//   clk, rst : clock, async active-low reset (empties the pipe)
//   vld_i    : handshake this cycle
//   data_i   : response data captured with the handshake
//   vld_o    : rvalid, RSP_LAT cycles after vld_i
//   data_o   : rdata, zero whenever vld_o is low
module core_rsp_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int RSP_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [RSP_LAT-1:0]    vld_q;
   logic [DATA_WIDTH-1:0] data_q [RSP_LAT];

   // Data is zeroed on entry when not valid, so the output needs no masking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < RSP_LAT; i++) data_q[i] <= '0;
      end else begin
         vld_q[0]  <= vld_i;
         data_q[0] <= vld_i ? data_i : '0;
         for (int i = 1; i < RSP_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[RSP_LAT-1];
   assign data_o = data_q[RSP_LAT-1];

endmodule

// File: rtl/core_mem_slave.sv
// Word-organised memory slave with programmable grant delay, outstanding
// limit and fixed response latency.
//   clk  : clock
//   rst  : async active-low reset (memory array is not reset)
//   slv  : core_mem_slave_if slave modport (req/addr/we/be/wdata in,
//          gnt/rvalid/rdata out)
//
// Grant FSM
//   state | meaning
//   IDLE  | no pending wait; with GNT_WAIT=0 grants directly from here
//   WAIT  | counting down GNT_WAIT cycles; grants when counter hits 0
module core_mem_slave import core_pkg::*; #(
   parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
   parameter int DATA_WIDTH = CORE_DATA_WIDTH,
   parameter int MEM_DEPTH  = 1024,
   parameter int GNT_WAIT   = 0,
   parameter int RSP_LAT    = 1,
   parameter int MAX_OUTST  = 2
) (
   input  logic               clk,
   input  logic               rst,
   core_mem_slave_if.slave    slv
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFFS     = $clog2(BE_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - OFFS;
   localparam int MEM_AW   = $clog2(MEM_DEPTH);
   localparam int CNT_W    = $clog2(MAX_OUTST + 1);

   gnt_state_e            state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [CNT_W-1:0]      outst_cnt_q, outst_cnt_d;
   logic                  full, gnt, hs, rvalid;
   logic [IDX_W-1:0]      idx;
   logic                  idx_ok;
   logic [DATA_WIDTH-1:0] rd_data, rdata;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic                  unused_addr_lsb;

   assign idx             = slv.addr[ADDR_WIDTH-1:OFFS];
   assign idx_ok          = {1'b0, idx} < (IDX_W+1)'(MEM_DEPTH);
   assign unused_addr_lsb = ^slv.addr[OFFS-1:0];

   // A response leaving this cycle frees a slot, so a new handshake may
   // land in the same cycle even at the limit.
   assign full = (outst_cnt_q == CNT_W'(MAX_OUTST)) && !rvalid;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      gnt     = 1'b0;
      case (state_q)
         IDLE: begin
            if (GNT_WAIT == 0) begin
               gnt = slv.req && !full;
            end else if (slv.req) begin
               state_d = WAIT;
               wcnt_d  = 4'(GNT_WAIT - 1);
            end
         end
         WAIT: begin
            if (!slv.req) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               gnt = !full;
               if (!full) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // gnt is combinational from req; gate it so reset forces it low at once.
   assign slv.gnt = gnt && rst;
   assign hs      = slv.req && slv.gnt;

   always_comb begin
      outst_cnt_d = outst_cnt_q;
      if (hs && !rvalid && outst_cnt_q != CNT_W'(MAX_OUTST))
         outst_cnt_d = outst_cnt_q + CNT_W'(1);
      else if (!hs && rvalid && outst_cnt_q != '0)
         outst_cnt_d = outst_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         outst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         outst_cnt_q <= outst_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hs && slv.we && idx_ok) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (slv.be[i]) mem_q[idx[MEM_AW-1:0]][i*8 +: 8] <= slv.wdata[i*8 +: 8];
         end
      end
   end

   // Writes respond with zero data; out-of-range reads return ERR_DATA.
   always_comb begin
      rd_data = '0;
      if (hs && !slv.we)
         rd_data = idx_ok ? mem_q[idx[MEM_AW-1:0]] : DATA_WIDTH'(ERR_DATA);
   end

   core_rsp_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSP_LAT    (RSP_LAT)
   ) u_rsp_pipe (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (hs),
      .data_i (rd_data),
      .vld_o  (rvalid),
      .data_o (rdata)
   );

   assign slv.rvalid = rvalid;
   assign slv.rdata  = rdata;

endmodule

// File: tb/tb_core_mem_slave.sv
// Directed bench for core_mem_slave using three parameterisations:
//   u0 : GNT_WAIT=0, RSP_LAT=1  (basic, byte enables, range, reset)
//   u1 : GNT_WAIT=3, RSP_LAT=2  (grant wait, dropped request)
//   u2 : GNT_WAIT=0, RSP_LAT=4  (outstanding limit, reset with traffic)
module tb_core_mem_slave;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   core_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0 (), m1 (), m2 ();

   core_mem_slave #(.MEM_DEPTH(16), .GNT_WAIT(0), .RSP_LAT(1), .MAX_OUTST(2))
      u0 (.clk(clk), .rst(rst_n), .slv(m0.slave));
   core_mem_slave #(.MEM_DEPTH(16), .GNT_WAIT(3), .RSP_LAT(2), .MAX_OUTST(2))
      u1 (.clk(clk), .rst(rst_n), .slv(m1.slave));
   core_mem_slave #(.MEM_DEPTH(16), .GNT_WAIT(0), .RSP_LAT(4), .MAX_OUTST(2))
      u2 (.clk(clk), .rst(rst_n), .slv(m2.slave));

   int          n_chk  = 0;
   int          n_pass = 0;
   int          max2   = 0;
   logic        s_gnt, s_rv;
   logic [31:0] s_rd;
   int          k, rd_idx, rsp_idx;
   bit          got, any_rv;
   logic [11:0] exp_g, exp_rv;

   always @(negedge clk) begin
      if (int'(u2.outst_cnt_q) > max2) max2 = int'(u2.outst_cnt_q);
   end

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_chk++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
   endtask

   // Drive one DUT for a cycle (called at posedge+1), sample at negedge.
   task automatic step(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
      case (d)
         0: begin m0.req = r; m0.we = w; m0.addr = a; m0.be = b; m0.wdata = wd; end
         1: begin m1.req = r; m1.we = w; m1.addr = a; m1.be = b; m1.wdata = wd; end
         default: begin m2.req = r; m2.we = w; m2.addr = a; m2.be = b; m2.wdata = wd; end
      endcase
      @(negedge clk);
      case (d)
         0: begin s_gnt = m0.gnt; s_rv = m0.rvalid; s_rd = m0.rdata; end
         1: begin s_gnt = m1.gnt; s_rv = m1.rvalid; s_rd = m1.rdata; end
         default: begin s_gnt = m2.gnt; s_rv = m2.rvalid; s_rd = m2.rdata; end
      endcase
      @(posedge clk);
      #1;
   endtask

   // Hold a request until granted, bounded.
   task automatic xfer(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
      bit g = 0;
      for (int i = 0; i < 20 && !g; i++) begin
         step(d, 1'b1, w, a, b, wd);
         g = s_gnt;
      end
      chk("xfer_gnt", 32'(g), 32'd1);
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      m0.req = 0; m0.we = 0; m0.addr = 0; m0.be = 0; m0.wdata = 0;
      m1.req = 0; m1.we = 0; m1.addr = 0; m1.be = 0; m1.wdata = 0;
      m2.req = 0; m2.we = 0; m2.addr = 0; m2.be = 0; m2.wdata = 0;
      repeat (2) @(posedge clk);
      #1;

      // ---- u0: reset state, first grant, basic write/read ----
      step(0, 1, 1, 32'h10, 4'hF, 32'hA5A5_5A5A);
      chk("rst_gnt", 32'(s_gnt), 32'd0);
      chk("rst_rvalid", 32'(s_rv), 32'd0);
      chk("rst_rdata", s_rd, 32'h0);
      rst_n = 1'b1;
      step(0, 1, 1, 32'h10, 4'hF, 32'hA5A5_5A5A);
      chk("first_gnt", 32'(s_gnt), 32'd1);
      step(0, 1, 0, 32'h10, 4'hF, 32'h0);
      chk("rd_gnt", 32'(s_gnt), 32'd1);
      chk("wr_rvalid", 32'(s_rv), 32'd1);
      chk("wr_rdata", s_rd, 32'h0);
      step(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("rd_rvalid", 32'(s_rv), 32'd1);
      chk("rd_data", s_rd, 32'hA5A5_5A5A);
      step(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("idle_rvalid", 32'(s_rv), 32'd0);
      chk("idle_rdata", s_rd, 32'h0);

      // ---- u0: byte enables, be=0 write, low address bits ----
      step(0, 1, 1, 32'h20, 4'hF, 32'hFFFF_FFFF);
      step(0, 1, 1, 32'h20, 4'h5, 32'h1122_3344);
      step(0, 1, 0, 32'h20, 4'hF, 32'h0);
      step(0, 1, 1, 32'h20, 4'h0, 32'h0);
      chk("be_data", s_rd, 32'hFF22_FF44);
      step(0, 1, 0, 32'h23, 4'hF, 32'h0);
      chk("be0_rvalid", 32'(s_rv), 32'd1);
      chk("be0_rdata", s_rd, 32'h0);
      step(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("be0_nop", s_rd, 32'hFF22_FF44);

      // ---- u0: out-of-range index (MEM_DEPTH=16 -> addr 0x40) ----
      step(0, 1, 1, 32'h00, 4'hF, 32'h600D_0000);
      step(0, 1, 1, 32'h40, 4'hF, 32'h1234_5678);
      step(0, 1, 0, 32'h40, 4'hF, 32'h0);
      step(0, 1, 0, 32'h00, 4'hF, 32'h0);
      chk("oob_rd", s_rd, 32'hDEAD_BEEF);
      step(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("oob_wr_drop", s_rd, 32'h600D_0000);
      idle(0, 1);

      // ---- u1: GNT_WAIT=3, RSP_LAT=2 ----
      for (int c = 1; c <= 4; c++) begin
         step(1, 1, 1, 32'h4, 4'hF, 32'hCAFE_0001);
         chk("gw_wr_gnt", 32'(s_gnt), (c == 4) ? 32'd1 : 32'd0);
      end
      step(1, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("gw_rv_early", 32'(s_rv), 32'd0);
      step(1, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("gw_rv_lat2", 32'(s_rv), 32'd1);
      step(1, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("gw_rv_once", 32'(s_rv), 32'd0);
      step(1, 1, 0, 32'h4, 4'hF, 32'h0);
      chk("drop_gnt_a", 32'(s_gnt), 32'd0);
      any_rv = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 32'h0, 4'h0, 32'h0);
         any_rv |= s_rv;
      end
      chk("drop_no_rv", 32'(any_rv), 32'd0);
      got = 0; k = 0;
      while (!got && k < 10) begin
         k++;
         step(1, 1, 0, 32'h4, 4'hF, 32'h0);
         got = s_gnt;
      end
      chk("gw_rd_cycles", 32'(k), 32'd4);
      step(1, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("gw_rd_early", 32'(s_rv), 32'd0);
      step(1, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("gw_rd_data", s_rd, 32'hCAFE_0001);

      // ---- u2: outstanding limit, RSP_LAT=4 ----
      for (int i = 0; i < 4; i++) xfer(2, 1, 32'(i * 4), 4'hF, 32'hB0B0_0000 | 32'(i));
      idle(2, 6);
      exp_g  = 12'h033;
      exp_rv = 12'h330;
      rd_idx = 0; rsp_idx = 0;
      for (int c = 0; c < 12; c++) begin
         step(2, rd_idx < 4, 0, 32'(rd_idx * 4), 4'hF, 32'h0);
         chk("ot_gnt", 32'(s_gnt), 32'(exp_g[c]));
         if (s_gnt) rd_idx++;
         chk("ot_rvalid", 32'(s_rv), 32'(exp_rv[c]));
         if (s_rv) begin
            chk("ot_rdata", s_rd, 32'hB0B0_0000 | 32'(rsp_idx));
            rsp_idx++;
         end
      end
      chk("ot_count", 32'(rsp_idx), 32'd4);
      chk("outst_max", 32'(max2), 32'd2);

      // ---- u2: reset with responses in flight ----
      step(2, 1, 0, 32'h0, 4'hF, 32'h0);
      step(2, 1, 0, 32'h4, 4'hF, 32'h0);
      step(2, 1, 0, 32'h8, 4'hF, 32'h0);
      step(2, 1, 0, 32'h8, 4'hF, 32'h0);
      #1;
      chk("pre_rst_rv", 32'(m2.rvalid), 32'd1);
      chk("pre_rst_rd", m2.rdata, 32'hB0B0_0000);
      rst_n = 1'b0;
      #1;
      chk("rst_gnt2", 32'(m2.gnt), 32'd0);
      chk("rst_rv2", 32'(m2.rvalid), 32'd0);
      chk("rst_rd2", m2.rdata, 32'h0);
      m2.req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      any_rv = 0;
      for (int i = 0; i < 8; i++) begin
         step(2, 0, 0, 32'h0, 4'h0, 32'h0);
         any_rv |= s_rv;
      end
      chk("no_stale_rv", 32'(any_rv), 32'd0);
      xfer(2, 0, 32'h8, 4'hF, 32'h0);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(2, 0, 0, 32'h0, 4'h0, 32'h0);
         got = s_rv;
      end
      chk("post_rst_rv", 32'(got), 32'd1);
      chk("post_rst_rd", s_rd, 32'hB0B0_0002);
      xfer(0, 0, 32'h10, 4'hF, 32'h0);
      step(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("mem_kept_rv", 32'(s_rv), 32'd1);
      chk("mem_kept_rd", s_rd, 32'hA5A5_5A5A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_mem_slave.md
CORE_MEM_SLAVE -- requirements
Module: core_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; BE_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter MEM_DEPTH, default 1024, number of DATA_WIDTH words.
REQ-004 Parameter GNT_WAIT, default 0, wait cycles from req high to gnt (0..15).
REQ-005 Parameter RSP_LAT, default 1, cycles from handshake to rvalid (1..8).
REQ-006 Parameter MAX_OUTST, default 2, maximum granted-but-unanswered transactions (1..8).
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 req  input  1  master request.
REQ-010 addr  input  ADDR_WIDTH  byte address.
REQ-011 we  input  1  1 = write, 0 = read.
REQ-012 be  input  BE_WIDTH  byte enables.
REQ-013 wdata  input  DATA_WIDTH  write data.
REQ-014 gnt  output  1  request accepted; handshake = req & gnt.
REQ-015 rvalid  output  1  response valid, one cycle per transaction.
REQ-016 rdata  output  DATA_WIDTH  read data, valid when rvalid.

Function
REQ-017 Word index = addr[ADDR_WIDTH-1:log2(BE_WIDTH)]; low address bits ignored.
REQ-018 Grant FSM states IDLE, WAIT; GNT_WAIT=0: gnt = req & !full combinationally in IDLE, WAIT never entered.
REQ-019 GNT_WAIT>0: IDLE + req -> WAIT, counter loaded GNT_WAIT-1; counter decrements each cycle; gnt = req & !full when counter==0; handshake -> IDLE.
REQ-020 req low while in WAIT -> IDLE next cycle, no gnt, no side effects.
REQ-021 full = (outst_cnt == MAX_OUTST) & !rvalid; gnt held low while full, FSM stays in WAIT with counter at 0.
REQ-022 outst_cnt: +1 on handshake, -1 on rvalid, unchanged on both same cycle; never exceeds MAX_OUTST or wraps below 0.
REQ-023 Write handshake: each byte with be[i]=1 updated at next edge; be=0 write is legal no-op; write still produces rvalid with rdata=0.
REQ-024 Read handshake: rdata sampled from array at handshake cycle; write handshake in cycle N visible to read handshake in cycle N+1.
REQ-025 Word index >= MEM_DEPTH: write dropped, read returns ERR_DATA, rvalid still produced.
REQ-026 rvalid asserted exactly RSP_LAT cycles after the handshake edge; responses strictly in order; back-to-back handshakes give back-to-back rvalid.
REQ-027 rdata = 0 whenever rvalid = 0.
REQ-028 No backpressure on responses: rvalid is never stalled.

Reset
REQ-029 rst low asynchronously forces gnt=0, rvalid=0, rdata=0, FSM=IDLE, wait counter=0, outst_cnt=0, response pipeline empty.
REQ-030 Reset mid-operation discards all in-flight responses; no rvalid for pre-reset handshakes after release.
REQ-031 Memory array contents are not reset.
REQ-032 First gnt possible in the first cycle after rst deasserts (GNT_WAIT=0).

Structure
REQ-033 Package core_pkg holds CORE_ADDR_WIDTH, CORE_DATA_WIDTH, CORE_BE_WIDTH, ERR_DATA (32'hDEAD_BEEF), and the grant FSM state enum.
REQ-034 Sub-module core_rsp_pipe: RSP_LAT-stage valid/data shift pipeline producing rvalid/rdata; top holds FSM, counters, array.

Verification
REQ-035 GNT_WAIT=0,RSP_LAT=1: write addr 0x10 wdata 0xA5A5_5A5A be 0xF, then read 0x10 -> gnt same cycle each, rvalid 1 cycle later, read rdata 0xA5A5_5A5A.
REQ-036 Byte enables: write 0xFFFF_FFFF, then write 0x1122_3344 be 0x5, read -> rdata 0xFF22_FF44.
REQ-037 GNT_WAIT=3,RSP_LAT=2: req held -> gnt on 4th req cycle; rvalid 2 cycles after handshake; req dropped after 1 cycle -> no gnt, no rvalid.
REQ-038 MAX_OUTST=2,RSP_LAT=4: 4 back-to-back reads -> gnt for first 2, gnt low until first rvalid, responses in order, outst_cnt never >2.
REQ-039 Read word index MEM_DEPTH -> rvalid with rdata 0xDEAD_BEEF; write there leaves array unchanged.
REQ-040 Assert rst with 2 responses in flight -> gnt/rvalid/rdata 0 immediately; no rvalid after release; earlier written data still readable.
